da_out_serializer: RTL

- Downstream stage of the 8-point distributed-arithmetic transform core.
- Captures the core's eight parallel signed coefficients z0..z7 when the core strobes in_valid, and rescales each one with an arithmetic right shift, optional rounding and saturation.
- Streams the eight results out one per beat on a valid/ready interface, coefficient 0 first.
- Double-buffered: one frame can be held in the capture bank while the previous frame drains.

---
 rtl/da_pkg.sv | 25 ++
 rtl/da_scale_sat.sv | 55 +++++
 rtl/da_out_serializer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/da_pkg.sv
// ---------------------------------------------------------------------------
// da_pkg
// Shared constants and types for the distributed-arithmetic transform core
// and its output serializer.
//   IN_WORD_SIZE  : input sample width of the DA core
//   OUT_WORD_SIZE : internal accumulator width of the DA core
//   N_COEF        : coefficients per frame (8-point transform)
//   IN_WIDTH      : width of each coefficient handed to the serializer
//   state_t       : serializer FSM states
// ---------------------------------------------------------------------------
package da_pkg;

    localparam int IN_WORD_SIZE  = 10;
    localparam int OUT_WORD_SIZE = 24;
    localparam int N_COEF        = 8;
    localparam int IN_WIDTH      = OUT_WORD_SIZE + 2;
    localparam int OUT_WIDTH     = 16;
    localparam int SHIFT         = 10;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/da_scale_sat.sv
// ---------------------------------------------------------------------------
// da_scale_sat
// Purely combinational rescaler: sign-extend by one guard bit, optionally add
// half an LSB of the result, arithmetic right shift, saturate to OUT_WIDTH.
// Build option: define DA_OUT_ROUND_EN for round-half-up, otherwise the shift
// truncates (floors toward minus infinity).
// Ports:
//   coef     in   IN_WIDTH   signed coefficient
//   out_data out  OUT_WIDTH  scaled, saturated result
//   out_sat  out  1          result was clipped
// ---------------------------------------------------------------------------
module da_scale_sat #(
    parameter int IN_WIDTH  = 26,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 10
) (
    input  logic signed [IN_WIDTH-1:0]  coef,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_sat
);

    localparam int EW = IN_WIDTH + 1;

`ifdef DA_OUT_ROUND_EN
    localparam logic signed [EW-1:0] ROUND_ADD = {{(EW-1){1'b0}}, 1'b1} << (SHIFT - 1);
`else
    localparam logic signed [EW-1:0] ROUND_ADD = '0;
`endif

    localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [EW-1:0] ext_val;
    logic signed [EW-1:0] biased_val;
    logic signed [EW-1:0] shifted_val;

    always_comb begin
        // The guard bit keeps the rounding addend from overflowing at the top
        // of the input range.
        ext_val     = {coef[IN_WIDTH-1], coef};
        biased_val  = ext_val + ROUND_ADD;
        shifted_val = biased_val >>> SHIFT;
        out_sat     = 1'b0;
        if (shifted_val > SAT_MAX) begin
            out_data = SAT_MAX[OUT_WIDTH-1:0];
            out_sat  = 1'b1;
        end else if (shifted_val < SAT_MIN) begin
            out_data = SAT_MIN[OUT_WIDTH-1:0];
            out_sat  = 1'b1;
        end else begin
            out_data = shifted_val[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/da_out_serializer.sv
// ---------------------------------------------------------------------------
// da_out_serializer
// Captures the DA core's eight coefficients on in_valid, rescales each one via
// da_scale_sat and streams them out one per beat (coefficient 0 first) on a
// valid/ready interface. A capture bank holds the next frame while the active
// bank drains; a frame arriving while the capture bank is still occupied is
// dropped and counted.
// Build option: DA_OUT_ROUND_EN selects round-half-up in da_scale_sat.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid, z0-z7 frame strobe and coefficients from the DA core
//   in_ready        capture bank empty (advisory, registered)
//   out_valid/ready output handshake
//   out_data        scaled coefficient, out_idx its index, out_last on idx 7
//   out_sat         current beat was clipped
//   drop_cnt        dropped-frame counter, saturating at 255
// ---------------------------------------------------------------------------
module da_out_serializer
    import da_pkg::*;
#(
    parameter int N_COEF    = da_pkg::N_COEF,
    parameter int IN_WIDTH  = da_pkg::IN_WIDTH,
    parameter int OUT_WIDTH = da_pkg::OUT_WIDTH,
    parameter int SHIFT     = da_pkg::SHIFT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic signed [IN_WIDTH-1:0]  z0,
    input  logic signed [IN_WIDTH-1:0]  z1,
    input  logic signed [IN_WIDTH-1:0]  z2,
    input  logic signed [IN_WIDTH-1:0]  z3,
    input  logic signed [IN_WIDTH-1:0]  z4,
    input  logic signed [IN_WIDTH-1:0]  z5,
    input  logic signed [IN_WIDTH-1:0]  z6,
    input  logic signed [IN_WIDTH-1:0]  z7,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic [2:0]                  out_idx,
    output logic                        out_last,
    output logic                        out_sat,
    output logic [7:0]                  drop_cnt
);

    logic signed [IN_WIDTH-1:0] z_in     [N_COEF];
    logic signed [IN_WIDTH-1:0] cap_bank [N_COEF];
    logic signed [IN_WIDTH-1:0] act_bank [N_COEF];

    state_t     state_reg, state_next;
    logic [2:0] idx_reg, idx_next;
    logic       cap_full_reg, cap_full_next;
    logic       in_ready_reg;
    logic [7:0] drop_cnt_reg;

    logic handshake, last_beat, transfer, capture, drop;
    logic signed [OUT_WIDTH-1:0] scaled_data;
    logic                        scaled_sat;

    assign z_in[0] = z0;
    assign z_in[1] = z1;
    assign z_in[2] = z2;
    assign z_in[3] = z3;
    assign z_in[4] = z4;
    assign z_in[5] = z5;
    assign z_in[6] = z6;
    assign z_in[7] = z7;

    assign handshake = (state_reg == SEND) && out_ready;
    assign last_beat = (idx_reg == 3'd7);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        transfer   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cap_full_reg) begin
                    transfer   = 1'b1;
                    idx_next   = 3'd0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (last_beat) begin
                        idx_next = 3'd0;
                        // A waiting frame reloads immediately: no bubble.
                        if (cap_full_reg) transfer = 1'b1;
                        else              state_next = IDLE;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A transfer frees the capture bank in the same edge, so a coincident
        // strobe is accepted rather than dropped.
        capture = in_valid && (!cap_full_reg || transfer);
        drop    = in_valid && cap_full_reg && !transfer;
        if (capture)       cap_full_next = 1'b1;
        else if (transfer) cap_full_next = 1'b0;
        else               cap_full_next = cap_full_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            idx_reg      <= 3'd0;
            cap_full_reg <= 1'b0;
            in_ready_reg <= 1'b1;
            drop_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            cap_full_reg <= cap_full_next;
            in_ready_reg <= !cap_full_next;
            if (drop && (drop_cnt_reg != 8'hFF))
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_COEF; i++) begin
                cap_bank[i] <= '0;
                act_bank[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_COEF; i++) begin
                if (capture)  cap_bank[i] <= z_in[i];
                if (transfer) act_bank[i] <= cap_bank[i];
            end
        end
    end

    da_scale_sat #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_scale (
        .coef     (act_bank[idx_reg]),
        .out_data (scaled_data),
        .out_sat  (scaled_sat)
    );

    // Beat fields are forced to zero outside SEND so the idle bus is quiet.
    assign out_valid = (state_reg == SEND);
    assign out_data  = out_valid ? scaled_data : '0;
    assign out_sat   = out_valid && scaled_sat;
    assign out_last  = out_valid && last_beat;
    assign out_idx   = idx_reg;
    assign in_ready  = in_ready_reg;
    assign drop_cnt  = drop_cnt_reg;

endmodule
